// File: rtl/acs_pmu.sv
// acs_pmu: add-compare-select / path-metric unit for the K=3, rate-1/2 (7,5) Viterbi decoder.
// Optional build macro ACS_NORM_COUNT_EN adds a saturating norm_count output.
module acs_pmu #(
  parameter int PM_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            refresh,
  input  logic [3:0]      branch_metric_00_0,
  input  logic [3:0]      branch_metric_00_1,
  input  logic [3:0]      branch_metric_01_0,
  input  logic [3:0]      branch_metric_01_1,
  input  logic [3:0]      branch_metric_10_0,
  input  logic [3:0]      branch_metric_10_1,
  input  logic [3:0]      branch_metric_11_0,
  input  logic [3:0]      branch_metric_11_1,
  input  logic            valid_in,
  input  logic [1:0]      bit_pair_input,
  input  logic            bit_valid,
  output logic [PM_W-1:0] path_metric_0,
  output logic [PM_W-1:0] path_metric_1,
  output logic [PM_W-1:0] path_metric_2,
  output logic [PM_W-1:0] path_metric_3,
  output logic [3:0]      decision,
  output logic            decision_valid,
  output logic [1:0]      best_state,
  output logic            norm_event,
`ifdef ACS_NORM_COUNT_EN
  output logic [7:0]      norm_count,
`endif
  output logic            running
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [PM_W:0] PM_HALF = {2'b01, {(PM_W-1){1'b0}}};

  state_t          state_r, state_s;
  logic [PM_W-1:0] pm_r [4];
  logic [PM_W-1:0] pm_s [4];
  logic [PM_W-1:0] load_pm_s [4];
  logic [3:0]      load_dec_s;
  logic [PM_W:0]   cand_a_s [4];
  logic [PM_W:0]   cand_b_s [4];
  logic [PM_W:0]   acs_raw_s [4];
  logic [PM_W:0]   acs_adj_s [4];
  logic [PM_W-1:0] acs_pm_s [4];
  logic [3:0]      acs_dec_s;
  logic            all_hi_s;
  logic [3:0]      dec_r, dec_s;
  logic            dv_r, dv_s;
  logic            norm_r, norm_s;
  logic [1:0]      best_r, best_s;

  // Hamming distance between the received pair and the branch label of (pred, u).
  function automatic logic [1:0] bm_f(input logic [1:0] rx, input logic [1:0] pred, input logic u);
    logic [1:0] diff;
    diff = rx ^ {u ^ pred[1] ^ pred[0], u ^ pred[0]};
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  function automatic logic [1:0] argmin_f(input logic [PM_W-1:0] m0, input logic [PM_W-1:0] m1,
                                          input logic [PM_W-1:0] m2, input logic [PM_W-1:0] m3);
    logic [1:0]      idx01, idx23;
    logic [PM_W-1:0] min01, min23;
    idx01 = (m1 < m0) ? 2'd1 : 2'd0;
    min01 = (m1 < m0) ? m1 : m0;
    idx23 = (m3 < m2) ? 2'd3 : 2'd2;
    min23 = (m3 < m2) ? m3 : m2;
    return (min23 < min01) ? idx23 : idx01;
  endfunction

  // Tree merge: state {C,B} keeps the cheaper of the A=0 / A=1 tree paths, ties to A=0.
  always_comb begin
    load_dec_s[0] = (branch_metric_10_0 < branch_metric_00_0);
    load_dec_s[1] = (branch_metric_11_0 < branch_metric_01_0);
    load_dec_s[2] = (branch_metric_10_1 < branch_metric_00_1);
    load_dec_s[3] = (branch_metric_11_1 < branch_metric_01_1);
    load_pm_s[0]  = PM_W'(load_dec_s[0] ? branch_metric_10_0 : branch_metric_00_0);
    load_pm_s[1]  = PM_W'(load_dec_s[1] ? branch_metric_11_0 : branch_metric_01_0);
    load_pm_s[2]  = PM_W'(load_dec_s[2] ? branch_metric_10_1 : branch_metric_00_1);
    load_pm_s[3]  = PM_W'(load_dec_s[3] ? branch_metric_11_1 : branch_metric_01_1);
  end

  // Add-compare-select: next state {u,s1} chooses between predecessors {s1,0} and {s1,1}.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      cand_a_s[n]  = {1'b0, pm_r[{n[0], 1'b0}]} + (PM_W+1)'(bm_f(bit_pair_input, {n[0], 1'b0}, n[1]));
      cand_b_s[n]  = {1'b0, pm_r[{n[0], 1'b1}]} + (PM_W+1)'(bm_f(bit_pair_input, {n[0], 1'b1}, n[1]));
      acs_dec_s[n] = (cand_b_s[n] < cand_a_s[n]);
      acs_raw_s[n] = acs_dec_s[n] ? cand_b_s[n] : cand_a_s[n];
    end
  end

  // Normalization clears the common MSB; saturation guards the store against wrap.
  always_comb begin
    all_hi_s = 1'b1;
    for (int n = 0; n < 4; n++) begin
      all_hi_s = all_hi_s & (acs_raw_s[n] >= PM_HALF);
    end
    for (int n = 0; n < 4; n++) begin
      acs_adj_s[n] = all_hi_s ? (acs_raw_s[n] - PM_HALF) : acs_raw_s[n];
      acs_pm_s[n]  = acs_adj_s[n][PM_W] ? {PM_W{1'b1}} : acs_adj_s[n][PM_W-1:0];
    end
  end

  // FSM next state and next register values; refresh overrides any accepted input.
  always_comb begin
    state_s = state_r;
    pm_s    = pm_r;
    dec_s   = dec_r;
    dv_s    = 1'b0;
    norm_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (valid_in) begin
          pm_s    = load_pm_s;
          dec_s   = load_dec_s;
          dv_s    = 1'b1;
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bit_valid) begin
          pm_s   = acs_pm_s;
          dec_s  = acs_dec_s;
          dv_s   = 1'b1;
          norm_s = all_hi_s;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    if (refresh) begin
      state_s = ST_IDLE;
      pm_s    = '{default: '0};
      dec_s   = 4'b0000;
      dv_s    = 1'b0;
      norm_s  = 1'b0;
    end else begin
      state_s = state_s;
    end
    best_s = argmin_f(pm_s[0], pm_s[1], pm_s[2], pm_s[3]);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      pm_r    <= '{default: '0};
      dec_r   <= 4'b0000;
      dv_r    <= 1'b0;
      norm_r  <= 1'b0;
      best_r  <= 2'd0;
    end else begin
      state_r <= state_s;
      pm_r    <= pm_s;
      dec_r   <= dec_s;
      dv_r    <= dv_s;
      norm_r  <= norm_s;
      best_r  <= best_s;
    end
  end

`ifdef ACS_NORM_COUNT_EN
  logic [7:0] norm_cnt_r;

  // Saturating count of normalization events.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      norm_cnt_r <= 8'd0;
    end else if (refresh) begin
      norm_cnt_r <= 8'd0;
    end else if (norm_s && (norm_cnt_r != 8'd255)) begin
      norm_cnt_r <= norm_cnt_r + 8'd1;
    end else begin
      norm_cnt_r <= norm_cnt_r;
    end
  end

  assign norm_count = norm_cnt_r;
`endif

  assign path_metric_0  = pm_r[0];
  assign path_metric_1  = pm_r[1];
  assign path_metric_2  = pm_r[2];
  assign path_metric_3  = pm_r[3];
  assign decision       = dec_r;
  assign decision_valid = dv_r;
  assign norm_event     = norm_r;
  assign best_state     = best_r;
  assign running        = (state_r == ST_RUN);

endmodule

// File: tb/tb_acs_pmu.sv
// Scoreboard bench for acs_pmu: directed stimulus pushes hand-computed responses,
// a negedge monitor pops and compares on every decision_valid.
module tb_acs_pmu;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       refresh = 1'b0;
  logic [3:0] bm_00_0 = 4'd0, bm_00_1 = 4'd0, bm_01_0 = 4'd0, bm_01_1 = 4'd0;
  logic [3:0] bm_10_0 = 4'd0, bm_10_1 = 4'd0, bm_11_0 = 4'd0, bm_11_1 = 4'd0;
  logic       valid_in = 1'b0;
  logic [1:0] bit_pair_input = 2'b00;
  logic       bit_valid = 1'b0;
  logic [5:0] path_metric_0, path_metric_1, path_metric_2, path_metric_3;
  logic [3:0] decision;
  logic       decision_valid;
  logic [1:0] best_state;
  logic       norm_event;
  logic       running;
`ifdef ACS_NORM_COUNT_EN
  logic [7:0] norm_count;
`endif

  acs_pmu #(.PM_W(6)) dut (
    .clk(clk), .rst(rst), .refresh(refresh),
    .branch_metric_00_0(bm_00_0), .branch_metric_00_1(bm_00_1),
    .branch_metric_01_0(bm_01_0), .branch_metric_01_1(bm_01_1),
    .branch_metric_10_0(bm_10_0), .branch_metric_10_1(bm_10_1),
    .branch_metric_11_0(bm_11_0), .branch_metric_11_1(bm_11_1),
    .valid_in(valid_in), .bit_pair_input(bit_pair_input), .bit_valid(bit_valid),
    .path_metric_0(path_metric_0), .path_metric_1(path_metric_1),
    .path_metric_2(path_metric_2), .path_metric_3(path_metric_3),
    .decision(decision), .decision_valid(decision_valid), .best_state(best_state),
    .norm_event(norm_event),
`ifdef ACS_NORM_COUNT_EN
    .norm_count(norm_count),
`endif
    .running(running)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] p0, p1, p2, p3;
    logic [3:0] dec;
    logic [1:0] best;
    logic       norm;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t mon_got;
  int   n_vec  = 0;
  int   n_miss = 0;

  always @(negedge clk) begin
    mon_got = {path_metric_0, path_metric_1, path_metric_2, path_metric_3, decision, best_state, norm_event};
    if (decision_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_dv: got decision_valid=1 pm=%0d,%0d,%0d,%0d, required no output",
                 path_metric_0, path_metric_1, path_metric_2, path_metric_3);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_got !== mon_e) begin
          n_miss++;
          $display("FAIL acs_vec: got pm=%0d,%0d,%0d,%0d dec=%b best=%0d norm=%b, required pm=%0d,%0d,%0d,%0d dec=%b best=%0d norm=%b",
                   mon_got.p0, mon_got.p1, mon_got.p2, mon_got.p3, mon_got.dec, mon_got.best, mon_got.norm,
                   mon_e.p0, mon_e.p1, mon_e.p2, mon_e.p3, mon_e.dec, mon_e.best, mon_e.norm);
        end
      end
    end else if (norm_event) begin
      n_vec++;
      n_miss++;
      $display("FAIL stray_norm: got norm_event=1 with decision_valid=0, required 0");
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_miss++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic push(input int p0, input int p1, input int p2, input int p3,
                      input logic [3:0] dec, input int best, input logic norm);
    exp_t e;
    e.p0 = 6'(p0); e.p1 = 6'(p1); e.p2 = 6'(p2); e.p3 = 6'(p3);
    e.dec = dec; e.best = 2'(best); e.norm = norm;
    exp_q.push_back(e);
  endtask

  task automatic load_tree(input logic [3:0] a00_0, input logic [3:0] a10_0, input logic [3:0] a01_0,
                           input logic [3:0] a11_0, input logic [3:0] a00_1, input logic [3:0] a10_1,
                           input logic [3:0] a01_1, input logic [3:0] a11_1);
    bm_00_0 = a00_0; bm_10_0 = a10_0; bm_01_0 = a01_0; bm_11_0 = a11_0;
    bm_00_1 = a00_1; bm_10_1 = a10_1; bm_01_1 = a01_1; bm_11_1 = a11_1;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic step(input logic [1:0] pair);
    bit_pair_input = pair;
    bit_valid = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its summary, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pm0", path_metric_0, 0);
    chk("rst_pm3", path_metric_3, 0);
    chk("rst_dec", decision, 0);
    chk("rst_dv", decision_valid, 0);
    chk("rst_best", best_state, 0);
    chk("rst_norm", norm_event, 0);
    chk("rst_running", running, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    step(2'b00);
    step(2'b11);
    step(2'b01);
    chk("idle_running", running, 0);

    // Tree load and first ACS step
    push(0, 1, 2, 5, 4'b0010, 0, 1'b0);
    load_tree(4'd0, 4'd3, 4'd4, 4'd1, 4'd2, 4'd2, 4'd5, 4'd5);
    chk("load_running", running, 1);
    push(0, 3, 1, 3, 4'b0100, 0, 1'b0);
    step(2'b00);

    // valid_in in RUN is ignored, metrics hold without bit_valid
    load_tree(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("hold_pm1", path_metric_1, 3);
    chk("hold_running", running, 1);

    // Refresh drops a concurrent pair
    refresh = 1'b1;
    bit_pair_input = 2'b11;
    bit_valid = 1'b1;
    @(posedge clk); #1;
    refresh = 1'b0;
    bit_valid = 1'b0;
    chk("refresh_running", running, 0);
    chk("refresh_pm1", path_metric_1, 0);
    chk("refresh_pm3", path_metric_3, 0);
    chk("refresh_dec", decision, 0);
    push(0, 1, 2, 5, 4'b0010, 0, 1'b0);
    load_tree(4'd0, 4'd3, 4'd4, 4'd1, 4'd2, 4'd2, 4'd5, 4'd5);
    push(0, 3, 1, 3, 4'b0100, 0, 1'b0);
    step(2'b00);

    // Asynchronous reset in the low phase of the clock
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_pm1", path_metric_1, 0);
    chk("arst_pm3", path_metric_3, 0);
    chk("arst_dec", decision, 0);
    chk("arst_running", running, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    step(2'b10);
    step(2'b00);
    chk("arst_idle_running", running, 0);

    // Grow all metrics from 15 to 31 in 3-step r=01 cycles, then normalize
    push(15, 15, 15, 15, 4'b0000, 0, 1'b0);
    load_tree(4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15);
    for (int k = 0; k < 16; k++) begin
      push(16 + k, 15 + k, 16 + k, 15 + k, 4'b0010, 1, 1'b0);
      step(2'b01);
      push(16 + k, 15 + k, 16 + k, 16 + k, 4'b0111, 1, 1'b0);
      step(2'b01);
      push(16 + k, 16 + k, 16 + k, 16 + k, 4'b0111, 0, 1'b0);
      step(2'b01);
    end
    push(31, 32, 31, 32, 4'b0100, 0, 1'b0);
    step(2'b00);
    push(32, 32, 31, 32, 4'b0001, 2, 1'b0);
    step(2'b11);
    push(33, 32, 33, 31, 4'b0010, 3, 1'b0);
    step(2'b01);
    // pre-normalization {33,32,32,32}
    push(1, 0, 0, 0, 4'b1110, 1, 1'b1);
    step(2'b00);
`ifdef ACS_NORM_COUNT_EN
    chk("norm_count", norm_count, 1);
`endif
    push(1, 0, 1, 0, 4'b0111, 1, 1'b0);
    step(2'b01);
    chk("norm_clear", norm_event, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5; i++) begin
      if (exp_q.size() != 0) begin
        @(posedge clk);
      end
    end
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: got %0d outstanding responses, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/acs_pmu.md
Name: acs_pmu

Overview:
- Add-compare-select / path-metric unit for the rate-1/2, K=3 Viterbi decoder (generators 7,5; 4 trellis states).
- Sits directly downstream of the third branch-metric stage, `bmu`.
- Loads the eight 3-bit-deep tree metrics from `bmu` and merges them into 4 initial path metrics.
- Then runs one ACS step per received bit pair and emits 4 survivor decision bits per step for the traceback unit.

Parameters:
- PM_W, 6, path-metric register width. Must be at least 6.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- refresh  input  1  synchronous restart; returns the block to IDLE.
- branch_metric_00_0 .. branch_metric_11_1  input  4 each (8 ports)  tree metrics from `bmu`; branch_metric_AB_C = metric of input path A,B,C.
- valid_in  input  1  tree metrics valid (bmu valid_out).
- bit_pair_input  input  2  received code pair; [1]=c0 (g=111), [0]=c1 (g=101).
- bit_valid  input  1  bit_pair_input valid this cycle.
- path_metric_0 .. path_metric_3  output  PM_W each  registered path metric of state 0..3.
- decision  output  4  survivor bit per state; bit n = LSB of the chosen predecessor of state n.
- decision_valid  output  1  one-cycle pulse with each new decision.
- best_state  output  2  index of the minimum path_metric; ties go to the lowest index.
- norm_event  output  1  pulse: normalization applied in this update.
- running  output  1  high in RUN.

Behaviour:
- Trellis definition:
  - State s = {u[t-1], u[t-2]} = {s1,s0}.
  - Input u gives next state {u,s1}.
  - Expected outputs: c0 = u^s1^s0, c1 = u^s0.
  - Branch metric BM = popcount(bit_pair_input ^ {c0,c1}), range 0..2.
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - path_metric_* = 0, decision = 0, decision_valid = 0, best_state = 0, norm_event = 0, running = 0.
- IDLE:
  - bit_valid is ignored.
  - On valid_in=1: for each state {C,B}, load PM = min(branch_metric_0B_C, branch_metric_1B_C), zero-extended.
  - decision bit for that state = chosen A; ties choose A=0.
  - decision_valid=1 the next cycle; FSM goes to RUN.
- RUN, on bit_valid=1:
  - Predecessors of next state {u,s1} are {s1,0} and {s1,1}.
  - candidate = PM[pred] + BM(pred,u).
  - Select the smaller candidate. decision bit = 0 if {s1,0} is chosen (including ties), 1 if {s1,1}.
  - All four states update in the same cycle; outputs are registered, latency 1 cycle.
  - decision_valid pulses one cycle per accepted pair.
  - valid_in is ignored in RUN.
- RUN, bit_valid=0: hold all metrics; decision_valid=0.
- Normalization:
  - If all four new metrics are >= 2^(PM_W-1), subtract 2^(PM_W-1) from each (clear the MSB) in the same update and pulse norm_event.
  - Intermediate sums are PM_W+1 bits wide; stored values never wrap.
- best_state and running track the registered metrics / FSM state.
- refresh=1 (synchronous, highest priority after rst):
  - Next cycle: FSM to IDLE, metrics and decision cleared, no decision_valid.
  - A valid_in or bit_valid in the same cycle is dropped.
- rst mid-RUN: immediate clear; the first valid_in after release reloads.

Optional Feature:
- ACS_NORM_COUNT_EN:
  - Defined: adds output port norm_count [7:0], a saturating count of norm_event pulses (stops at 255), cleared by rst and refresh.
  - Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset values: hold rst=0 for 2 cycles -> all outputs 0, running=0; bit_valid pulses while in IDLE -> no decision_valid.
- Tree load:
  - Stimulus: valid_in with bm_00_0=0, bm_10_0=3, bm_01_0=4, bm_11_0=1, bm_00_1=2, bm_10_1=2, bm_01_1=5, bm_11_1=5.
  - Next cycle: PM = {0,1,2,5}, decision = 4'b0010, best_state = 0, decision_valid = 1, running = 1.
- ACS step: continuing from the load, bit_pair_input=00 with bit_valid=1 -> PM = {0,3,1,3}, decision = 4'b0100, best_state = 0, one decision_valid pulse.
- Normalization: drive pre-normalization metrics to {33,34,35,36} with PM_W=6 -> stored {1,2,3,4} and norm_event=1 for one cycle; the ACS_NORM_COUNT_EN build shows norm_count incremented by 1.
- Refresh: refresh=1 in RUN together with bit_valid=1 -> the pair is dropped, next cycle running=0 and metrics 0; a later valid_in reloads as in the tree-load case.
- Async reset: rst=0 mid-cycle during RUN -> outputs clear without waiting for a clock edge; after release, IDLE behaviour as in the reset-values case.
